// File: rtl/urx_frame_parser.sv
// Receive-side framing stage: hunts for SOF, collects a length-prefixed payload,
// verifies an additive checksum and commits good payloads into a double-buffered store.
module urx_frame_parser #(
  parameter logic [7:0]  SOF          = 8'hA5,
  parameter int unsigned MAX_LEN      = 16,
  parameter int unsigned TIMEOUT_CLKS = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_dat,
  input  logic       rx_ok,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_dat,
  output logic [4:0] frm_len,
  output logic       frm_ok,
  output logic       frm_err,
  output logic [1:0] err_code,
  output logic [7:0] frm_cnt,
  output logic       busy
);

  localparam int unsigned AW = $clog2(MAX_LEN);
  localparam int unsigned CW = $clog2(TIMEOUT_CLKS + 1);

  typedef enum logic [1:0] {S_HUNT, S_LEN, S_PAY, S_CHK} state_t;

  state_t          state;
  logic            bank_sel;
  logic [4:0]      len;
  logic [7:0]      sum;
  logic [AW-1:0]   idx;
  logic [CW-1:0]   idle_cnt;
  logic [7:0]      mem [2*MAX_LEN];
  logic            timeout_c;
  logic            wr_en_c;

  assign timeout_c = (state != S_HUNT) && !rx_ok && (idle_cnt == CW'(TIMEOUT_CLKS - 1));
  assign wr_en_c   = rx_ok && (state == S_PAY);

  // Payload storage; the staging bank is always the one not selected for reads.
  always_ff @(posedge clk) begin
    if (wr_en_c) mem[{~bank_sel, idx}] <= rx_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_dat <= 8'd0;
    else        rd_dat <= mem[{bank_sel, rd_addr[AW-1:0]}];
  end

  // Inter-byte idle counter, only meaningful inside a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         idle_cnt <= '0;
    else if (rx_ok || state == S_HUNT)  idle_cnt <= '0;
    else                                idle_cnt <= idle_cnt + CW'(1);
  end

  // Frame FSM; busy is updated alongside every state change so it mirrors the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_HUNT;
      bank_sel <= 1'b0;
      len      <= 5'd0;
      sum      <= 8'd0;
      idx      <= '0;
      frm_len  <= 5'd0;
      frm_ok   <= 1'b0;
      frm_err  <= 1'b0;
      err_code <= 2'd0;
      frm_cnt  <= 8'd0;
      busy     <= 1'b0;
    end else begin
      frm_ok  <= 1'b0;
      frm_err <= 1'b0;
      if (timeout_c) begin
        state    <= S_HUNT;
        busy     <= 1'b0;
        frm_err  <= 1'b1;
        err_code <= 2'd3;
      end else if (rx_ok) begin
        case (state)
          S_HUNT: begin
            if (rx_dat == SOF) begin
              state <= S_LEN;
              busy  <= 1'b1;
            end
          end
          S_LEN: begin
            len <= 5'(rx_dat);
            sum <= rx_dat;
            idx <= '0;
            if (rx_dat > 8'(MAX_LEN)) begin
              state    <= S_HUNT;
              busy     <= 1'b0;
              frm_err  <= 1'b1;
              err_code <= 2'd2;
            end else if (rx_dat == 8'd0) begin
              state <= S_CHK;
            end else begin
              state <= S_PAY;
            end
          end
          S_PAY: begin
            sum <= sum + rx_dat;
            idx <= idx + AW'(1);
            if (5'(idx) == len - 5'd1) state <= S_CHK;
          end
          S_CHK: begin
            state <= S_HUNT;
            busy  <= 1'b0;
            if (rx_dat == sum) begin
              bank_sel <= ~bank_sel;
              frm_len  <= len;
              frm_cnt  <= frm_cnt + 8'd1;
              frm_ok   <= 1'b1;
            end else begin
              frm_err  <= 1'b1;
              err_code <= 2'd1;
            end
          end
          default: begin
            state <= S_HUNT;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_urx_frame_parser.sv
// Randomized scoreboard bench for urx_frame_parser: a frame-level model predicts each
// commit/drop, a monitor compares every frm_ok/frm_err pulse against the queued prediction.
module tb_urx_frame_parser;

  localparam int unsigned T  = 64;
  localparam int unsigned ML = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_dat;
  logic       rx_ok;
  logic [3:0] rd_addr;
  logic [7:0] rd_dat;
  logic [4:0] frm_len;
  logic       frm_ok;
  logic       frm_err;
  logic [1:0] err_code;
  logic [7:0] frm_cnt;
  logic       busy;

  urx_frame_parser #(.SOF(8'hA5), .MAX_LEN(ML), .TIMEOUT_CLKS(T)) dut (
    .clk(clk), .rst_n(rst_n), .rx_dat(rx_dat), .rx_ok(rx_ok), .rd_addr(rd_addr),
    .rd_dat(rd_dat), .frm_len(frm_len), .frm_ok(frm_ok), .frm_err(frm_err),
    .err_code(err_code), .frm_cnt(frm_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         ok;
    logic [1:0] code;
    logic [4:0] len;
    logic [7:0] cnt;
  } exp_t;

  int         checks = 0;
  int         errors = 0;
  int         fixed_gap = -1;
  int         goods;
  exp_t       sbq[$];
  logic [7:0] pay  [ML];
  logic [7:0] comm [ML];
  logic [7:0] m_cnt;
  logic [4:0] m_len;
  logic [1:0] m_code;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_dat = b;
    rx_ok  = 1'b1;
    @(posedge clk);
    #1 rx_ok = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic gap();
    if (fixed_gap >= 0) idle(fixed_gap);
    else                idle(int'($urandom_range(0, 3)));
  endtask

  // Frame-level model: outcome follows from LEN and the checksum rule alone.
  task automatic do_frame(input logic [7:0] len_f, input logic [7:0] delta);
    logic [7:0] s;
    exp_t       e;
    if (len_f > 8'(ML)) begin
      m_code = 2'd2;
      e = '{0, m_code, m_len, m_cnt};
      sbq.push_back(e);
      send_byte(8'hA5); gap(); send_byte(len_f); idle(2);
      return;
    end
    s = len_f;
    for (int i = 0; i < int'(len_f); i++) s = s + pay[i];
    if (delta == 8'd0) begin
      m_cnt = m_cnt + 8'd1;
      m_len = 5'(len_f);
      for (int i = 0; i < int'(len_f); i++) comm[i] = pay[i];
    end else begin
      m_code = 2'd1;
    end
    e = '{delta == 8'd0, m_code, m_len, m_cnt};
    sbq.push_back(e);
    send_byte(8'hA5); gap(); send_byte(len_f);
    for (int i = 0; i < int'(len_f); i++) begin
      gap(); send_byte(pay[i]);
    end
    gap(); send_byte(s + delta);
    idle(2);
  endtask

  task automatic check_reads();
    for (int i = 0; i < int'(m_len); i++) begin
      rd_addr = 4'(i);
      @(posedge clk);
      #1 chk("rd_dat", rd_dat, comm[i]);
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_rd_dat", rd_dat, 0);
    chk("rst_frm_len", frm_len, 0);
    chk("rst_frm_ok", frm_ok, 0);
    chk("rst_frm_err", frm_err, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_frm_cnt", frm_cnt, 0);
    chk("rst_busy", busy, 0);
  endtask

  // Monitor: every completion pulse must match the oldest prediction.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (frm_ok || frm_err)) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got ok=%0b err=%0b expected no pulse at %0t",
                 frm_ok, frm_err, $time);
      end else begin
        e = sbq.pop_front();
        chk("mon_frm_ok", frm_ok, e.ok);
        chk("mon_frm_err", frm_err, !e.ok);
        chk("mon_err_code", err_code, e.code);
        chk("mon_frm_len", frm_len, e.len);
        chk("mon_frm_cnt", frm_cnt, e.cnt);
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rx_ok = 1'b0; rx_dat = 8'd0; rd_addr = 4'd0;
    m_cnt = 8'd0; m_len = 5'd0; m_code = 2'd0;
    repeat (3) @(posedge clk);
    #1 check_reset_vals();
    rst_n = 1'b1;
    idle(2);

    // Good frame, then a bad checksum that must not disturb the committed data.
    pay[0] = 8'h12; pay[1] = 8'h34;
    do_frame(8'd2, 8'd0);
    check_reads();
    chk("err_code_after_good", err_code, 0);
    do_frame(8'd2, 8'd1);
    check_reads();

    // Oversized length: dropped right after LEN, busy falls next cycle.
    m_code = 2'd2;
    sbq.push_back('{0, m_code, m_len, m_cnt});
    send_byte(8'hA5);
    chk("busy_after_sof", busy, 1);
    send_byte(8'h11);
    chk("busy_after_len_err", busy, 0);
    idle(2);

    do_frame(8'd0, 8'd0);
    for (int i = 0; i < ML; i++) pay[i] = 8'h01;
    do_frame(8'd16, 8'd0);
    check_reads();

    // Timeout after T idle clocks inside a frame.
    m_code = 2'd3;
    sbq.push_back('{0, m_code, m_len, m_cnt});
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h12);
    idle(T - 1);
    chk("busy_before_timeout", busy, 1);
    chk("no_err_before_timeout", frm_err, 0);
    idle(1);
    chk("timeout_err", frm_err, 1);
    chk("timeout_code", err_code, 3);
    chk("busy_after_timeout", busy, 0);
    idle(2);

    // Every byte lands exactly on the terminal count: rx_ok must win.
    pay[0] = 8'h12; pay[1] = 8'h34;
    fixed_gap = T - 1;
    do_frame(8'd2, 8'd0);
    fixed_gap = -1;
    check_reads();

    // Leading garbage is ignored; SOF inside a frame is payload.
    send_byte(8'h00); send_byte(8'hFF);
    for (int i = 0; i < 5; i++) begin
      logic [7:0] g;
      g = 8'($urandom_range(0, 255));
      if (g == 8'hA5) g = 8'h5A;
      send_byte(g);
    end
    pay[0] = 8'hA5;
    do_frame(8'd1, 8'd0);
    check_reads();

    // Reset mid-payload.
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    rst_n = 1'b0;
    #1 check_reset_vals();
    m_cnt = 8'd0; m_len = 5'd0; m_code = 2'd0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    for (int i = 0; i < 3; i++) pay[i] = 8'($urandom_range(0, 255));
    do_frame(8'd3, 8'd0);
    check_reads();

    // Random traffic until the good-frame counter wraps.
    goods = 0;
    while (goods < 260) begin
      logic [7:0] lf;
      logic [7:0] dl;
      if ($urandom_range(0, 15) == 0) lf = 8'($urandom_range(ML + 1, 255));
      else                            lf = 8'($urandom_range(0, ML));
      dl = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
      for (int i = 0; i < ML; i++) pay[i] = 8'($urandom_range(0, 255));
      if (lf <= 8'(ML) && dl == 8'd0) goods++;
      do_frame(lf, dl);
      check_reads();
    end
    chk("frm_cnt_final", frm_cnt, m_cnt);

    for (int i = 0; i < 50 && sbq.size() != 0; i++) @(posedge clk);
    chk("sb_drain", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/urx_frame_parser.md
# urx_frame_parser

Receive-side framing stage placed directly downstream of the UART byte receiver (`URXD1B`). It consumes the receiver's byte/strobe pair, hunts for a start-of-frame byte, collects a length-prefixed payload, and verifies an additive checksum. Good payloads are committed into a double-buffered store that the display/control logic reads through a synchronous read port. Bad frames are dropped and reported with an error code.

## Interface
- `SOF`, 8'hA5, start-of-frame byte
- `MAX_LEN`, 16, maximum payload bytes (power of two, ≤ 16)
- `TIMEOUT_CLKS`, 500000, allowed idle clocks between bytes inside a frame (10 ms at 50 MHz)

Ports:
- `clk`  in  1  system clock (F50MHz domain)
- `rst_n`  in  1  reset, asynchronous, active-low
- `rx_dat`  in  8  received byte from `URXD1B.RXD`
- `rx_ok`  in  1  one-cycle strobe from `URXD1B.ok`; `rx_dat` is valid only in that cycle
- `rd_addr`  in  4  read index into the committed payload
- `rd_dat`  out  8  committed payload byte, registered
- `frm_len`  out  5  length of the last committed frame (0..MAX_LEN)
- `frm_ok`  out  1  one-cycle pulse: frame committed
- `frm_err`  out  1  one-cycle pulse: frame dropped
- `err_code`  out  2  cause of the last drop: 1 = checksum, 2 = length, 3 = timeout; holds until the next drop
- `frm_cnt`  out  8  good-frame counter, wraps 255→0
- `busy`  out  1  high while the FSM is not in HUNT

## Operation
- Frame format: `SOF`, `LEN`, `LEN` payload bytes, `CHK`.
  - `CHK` = (LEN + Σpayload) mod 256.
- FSM states: HUNT, LEN, PAY, CHK. All transitions occur only on `rx_ok`, except the timeout.
  - HUNT: if `rx_dat`==SOF, go to LEN. Any other byte is ignored silently, with no error.
  - LEN: latch `LEN` and set sum = `LEN`.
    - If LEN > MAX_LEN: pulse `frm_err`, set err_code = 2, go to HUNT.
    - Else if LEN == 0: go to CHK.
    - Else: go to PAY with idx = 0.
  - PAY: write `rx_dat` into the staging bank at idx, add it to sum (8-bit wrap), and increment idx. When idx reaches LEN-1 on this byte, go to CHK.
  - CHK: if `rx_dat`==sum, commit the frame:
    - Toggle the bank select so staging becomes committed.
    - Set `frm_len` = LEN.
    - Increment `frm_cnt` and pulse `frm_ok`.
    - Else pulse `frm_err` with err_code = 1.
    - Either way, go to HUNT.
- A SOF value received in LEN, PAY or CHK is treated as data, not as a resync.
- Storage: two banks of MAX_LEN × 8 bits.
  - The committed bank is never written.
  - A dropped frame leaves the committed bank, `frm_len` and `frm_cnt` unchanged.
- Timeout: an idle counter clears on every `rx_ok` and whenever the FSM is in HUNT.
  - In LEN, PAY or CHK, when the counter reaches TIMEOUT_CLKS-1 with no `rx_ok`: pulse `frm_err`, set err_code = 3, go to HUNT.
  - If `rx_ok` arrives in the same cycle as the timeout, `rx_ok` wins and no timeout is raised.
- `rd_addr` ≥ `frm_len` returns stale bank contents. This is not an error.

## Timing
- Reset values:
  - FSM = HUNT, bank select = 0.
  - `rd_dat` = 0, `frm_len` = 0, `frm_ok` = 0, `frm_err` = 0, `err_code` = 0, `frm_cnt` = 0, `busy` = 0.
  - Idle counter = 0.
  - Bank RAM contents are not reset.
- `frm_ok` and `frm_err` are high for exactly the one cycle after the `rx_ok` (or timeout) that decides the frame.
- `frm_len`, `frm_cnt` and the bank select update in the same cycle that `frm_ok` rises.
- `rd_dat` has one-cycle read latency from `rd_addr`. It reflects a new commit from the first read issued in the `frm_ok` cycle, i.e. the data appears in the cycle after that.
- `busy` is registered from the FSM state: high from the cycle after the SOF byte until the cycle after the deciding event.
- `rx_ok` pulses are at least one UART byte apart (≥ ~5000 clocks). Back-to-back strobes still need no pipeline bubble: one byte is processed per `rx_ok`.
- Reset asserted mid-frame:
  - Aborts immediately to HUNT.
  - The committed bank and `frm_len` are reset to bank 0 / length 0.
  - No `frm_err` is issued.

## Test plan
- Good frame: `A5 02 12 34 48` → `frm_ok` pulse, `frm_len`=2, `frm_cnt`=1, rd_addr 0/1 → `12`/`34`, `err_code` stays 0.
- Bad checksum: `A5 02 12 34 49` after the good frame → `frm_err` pulse, `err_code`=1, rd_addr 0 still reads `12`, `frm_cnt`=1.
- Length limits:
  - `A5 11` → `frm_err`, `err_code`=2, `busy` low next cycle.
  - `A5 00 00` → `frm_ok`, `frm_len`=0.
  - `A5 10` + 16 bytes `01` + `20` → `frm_ok`, `frm_len`=16.
- Timeout: `A5 02 12` then idle TIMEOUT_CLKS clocks → `frm_err`, `err_code`=3. Repeat with `rx_ok` landing exactly on the terminal count → no error, frame continues.
- Garbage and resync:
  - `00 FF A5 01 A5 A6` → one `frm_ok`, payload `A5`, no `frm_err` for the leading bytes.
  - Assert `rst_n` low mid-PAY → all outputs at reset values, next clean frame accepted.
- Counter wrap: send 256 good frames → `frm_cnt` returns to 0. Bank alternates every frame; reads always return the latest frame.
